// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense path.
package vend_pkg;

  localparam int CREDIT_W = 2;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = 2'd3;
  localparam int PHASE_W = 3;

  localparam int DEF_COFFEE_PRICE    = 2;
  localparam int DEF_SPRITE_PRICE    = 1;
  localparam int DEF_DISPENSE_CYCLES = 4;
  localparam int DEF_COOLDOWN_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_e;

  typedef enum logic {
    DRINK_COFFEE = 1'b0,
    DRINK_SPRITE = 1'b1
  } drink_e;

  // Returns {overflow, new_credit}: credit - deduct + coin, clipped at CREDIT_MAX.
  // Overflow is only possible when a coin was added, so it doubles as the
  // coin-return condition.
  function automatic logic [CREDIT_W:0] credit_apply(
    input logic [CREDIT_W-1:0] credit,
    input logic [CREDIT_W-1:0] deduct,
    input logic                coin
  );
    logic [CREDIT_W:0] sum;
    sum = {1'b0, credit} - {1'b0, deduct} + {{CREDIT_W{1'b0}}, coin};
    if (sum > {1'b0, CREDIT_MAX}) begin
      return {1'b1, CREDIT_MAX};
    end
    return {1'b0, sum[CREDIT_W-1:0]};
  endfunction

endpackage

// File: rtl/vend_dispense_arbiter_if.sv
// Sensor/button inputs and dispense/status outputs of the vending arbiter.
interface vend_dispense_arbiter_if;
  import vend_pkg::*;

  logic                i_coin;
  logic                i_coffee;
  logic                i_sprite;
  logic                o_coffee;
  logic                o_sprite;
  logic                o_led_coffee;
  logic                o_led_sprite;
  logic [CREDIT_W-1:0] o_credit;
  logic                o_busy;
  logic                o_coin_return;
  logic                o_deny;

  // Arbiter side
  modport slave (
    input  i_coin, i_coffee, i_sprite,
    output o_coffee, o_sprite, o_led_coffee, o_led_sprite,
           o_credit, o_busy, o_coin_return, o_deny
  );

  // Machine front-panel / driver side
  modport master (
    output i_coin, i_coffee, i_sprite,
    input  o_coffee, o_sprite, o_led_coffee, o_led_sprite,
           o_credit, o_busy, o_coin_return, o_deny
  );

endinterface

// File: rtl/vend_edge_detect.sv
// Rising-edge detector: one-cycle pulse when the level goes 0 -> 1.
// The previous-level register clears in reset, so a level held high across
// reset release shows up as an edge on the first non-reset cycle.
module vend_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  // Remember the level from the previous cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Coin credit, request pending flags and shared-chute dispense arbitration.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | chute free, waiting for a pending request
// ST_GRANT    | pick a drink (round-robin if both pending), check credit
// ST_DISPENSE | strobe the selected drink for DISPENSE_CYCLES cycles
// ST_COOLDOWN | chute settling gap of COOLDOWN_CYCLES cycles
module vend_dispense_arbiter
  import vend_pkg::*;
#(
  parameter int COFFEE_PRICE    = DEF_COFFEE_PRICE,
  parameter int SPRITE_PRICE    = DEF_SPRITE_PRICE,
  parameter int DISPENSE_CYCLES = DEF_DISPENSE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input logic                     clk,
  input logic                     rst,
  vend_dispense_arbiter_if.slave  io_vend
);

  localparam logic [CREDIT_W-1:0] P_COFFEE  = CREDIT_W'(COFFEE_PRICE);
  localparam logic [CREDIT_W-1:0] P_SPRITE  = CREDIT_W'(SPRITE_PRICE);
  localparam logic [PHASE_W-1:0]  DISP_LOAD = PHASE_W'(DISPENSE_CYCLES - 1);
  localparam logic [PHASE_W-1:0]  COOL_LOAD = PHASE_W'(COOLDOWN_CYCLES - 1);

  logic w_coin_edge;
  logic w_coffee_edge;
  logic w_sprite_edge;

  state_e              r_state,  w_state_nxt;
  logic [PHASE_W-1:0]  r_cnt,    w_cnt_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic                r_pend_coffee, w_pend_coffee_nxt;
  logic                r_pend_sprite, w_pend_sprite_nxt;
  drink_e              r_ptr,    w_ptr_nxt;
  drink_e              r_sel,    w_sel_nxt;
  logic                r_coin_return, w_coin_return_nxt;
  logic                r_deny,   w_deny_nxt;

  drink_e              w_pick;
  logic [CREDIT_W-1:0] w_pick_price;
  logic [CREDIT_W-1:0] w_deduct;
  logic                w_clr_coffee;
  logic                w_clr_sprite;
  logic [CREDIT_W:0]   w_credit_res;

  vend_edge_detect u_edge_coin (
    .clk     (clk),
    .rst     (rst),
    .i_level (io_vend.i_coin),
    .o_pulse (w_coin_edge)
  );

  vend_edge_detect u_edge_coffee (
    .clk     (clk),
    .rst     (rst),
    .i_level (io_vend.i_coffee),
    .o_pulse (w_coffee_edge)
  );

  vend_edge_detect u_edge_sprite (
    .clk     (clk),
    .rst     (rst),
    .i_level (io_vend.i_sprite),
    .o_pulse (w_sprite_edge)
  );

  // Next-state, grant decision, credit update and pending-flag bookkeeping
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ptr_nxt    = r_ptr;
    w_sel_nxt    = r_sel;
    w_deduct     = '0;
    w_clr_coffee = 1'b0;
    w_clr_sprite = 1'b0;
    w_deny_nxt   = 1'b0;

    if (r_pend_coffee && r_pend_sprite) begin
      w_pick = r_ptr;
    end else if (r_pend_coffee) begin
      w_pick = DRINK_COFFEE;
    end else begin
      w_pick = DRINK_SPRITE;
    end
    w_pick_price = (w_pick == DRINK_COFFEE) ? P_COFFEE : P_SPRITE;

    case (r_state)
      ST_IDLE: begin
        if (r_pend_coffee || r_pend_sprite) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // The flag is consumed either way; a short credit means an earlier
        // grant already spent what this request was accepted against.
        w_clr_coffee = (w_pick == DRINK_COFFEE);
        w_clr_sprite = (w_pick == DRINK_SPRITE);
        if (r_credit >= w_pick_price) begin
          w_deduct    = w_pick_price;
          w_sel_nxt   = w_pick;
          w_ptr_nxt   = (w_pick == DRINK_COFFEE) ? DRINK_SPRITE : DRINK_COFFEE;
          w_cnt_nxt   = DISP_LOAD;
          w_state_nxt = ST_DISPENSE;
        end else begin
          w_deny_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DISPENSE: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = COOL_LOAD;
          w_state_nxt = ST_COOLDOWN;
        end else begin
          w_cnt_nxt = r_cnt - PHASE_W'(1);
        end
      end
      ST_COOLDOWN: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - PHASE_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_credit_res      = credit_apply(r_credit, w_deduct, w_coin_edge);
    w_credit_nxt      = w_credit_res[CREDIT_W-1:0];
    w_coin_return_nxt = w_credit_res[CREDIT_W];

    // Acceptance is judged against the credit held at the press
    w_pend_coffee_nxt = (r_pend_coffee & ~w_clr_coffee) |
                        (w_coffee_edge & ~r_pend_coffee & (r_credit >= P_COFFEE));
    w_pend_sprite_nxt = (r_pend_sprite & ~w_clr_sprite) |
                        (w_sprite_edge & ~r_pend_sprite & (r_credit >= P_SPRITE));
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_credit      <= '0;
      r_pend_coffee <= 1'b0;
      r_pend_sprite <= 1'b0;
      r_ptr         <= DRINK_COFFEE;
      r_sel         <= DRINK_COFFEE;
      r_coin_return <= 1'b0;
      r_deny        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_credit      <= w_credit_nxt;
      r_pend_coffee <= w_pend_coffee_nxt;
      r_pend_sprite <= w_pend_sprite_nxt;
      r_ptr         <= w_ptr_nxt;
      r_sel         <= w_sel_nxt;
      r_coin_return <= w_coin_return_nxt;
      r_deny        <= w_deny_nxt;
    end
  end

  assign io_vend.o_coffee      = (r_state == ST_DISPENSE) && (r_sel == DRINK_COFFEE);
  assign io_vend.o_sprite      = (r_state == ST_DISPENSE) && (r_sel == DRINK_SPRITE);
  assign io_vend.o_led_coffee  = (r_credit >= P_COFFEE);
  assign io_vend.o_led_sprite  = (r_credit >= P_SPRITE);
  assign io_vend.o_credit      = r_credit;
  assign io_vend.o_busy        = (r_state != ST_IDLE);
  assign io_vend.o_coin_return = r_coin_return;
  assign io_vend.o_deny        = r_deny;

endmodule

// File: doc/vend_dispense_arbiter.md
VEND_DISPENSE_ARBITER -- requirements
Module: vend_dispense_arbiter

Interface
REQ-001 SHALL have parameter COFFEE_PRICE, default 2: coins deducted per coffee, range 1..3.
REQ-002 SHALL have parameter SPRITE_PRICE, default 1: coins deducted per sprite, range 1..3.
REQ-003 SHALL have parameter DISPENSE_CYCLES, default 4: length of a dispense pulse in clk cycles, minimum 1.
REQ-004 SHALL have parameter COOLDOWN_CYCLES, default 2: idle gap after each dispense, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_coin, input, 1 bit: coin sensor level; each rising edge is one coin.
REQ-008 SHALL have ports i_coffee and i_sprite, input, 1 bit each: button levels; each rising edge is one request.
REQ-009 SHALL have ports o_coffee and o_sprite, output, 1 bit each: shared-chute dispense strobes, mutually exclusive.
REQ-010 SHALL have ports o_led_coffee and o_led_sprite, output, 1 bit each: high while credit >= the respective price.
REQ-011 SHALL have port o_credit, output, 2 bits: current credit, for the BCD/segment path.
REQ-012 SHALL have port o_busy, output, 1 bit: high in GRANT, DISPENSE and COOLDOWN.
REQ-013 SHALL have ports o_coin_return and o_deny, output, 1 bit each: single-cycle event pulses.

Function
REQ-014 SHALL detect rising edges by comparing each input with its registered previous value.
REQ-015 SHALL raise credit by 1 on each coin edge, saturating at 3.
REQ-016 SHALL pulse o_coin_return for 1 cycle when a coin edge arrives at credit 3, leaving credit unchanged.
REQ-017 SHALL set pend_coffee (resp. pend_sprite) on a button edge only if credit >= price in that cycle; otherwise the request is ignored.
REQ-018 SHALL ignore a button edge whose pending flag is already set (no queueing beyond 1 per drink).
REQ-019 SHALL implement FSM states IDLE, GRANT, DISPENSE and COOLDOWN.
REQ-020 SHALL go IDLE -> GRANT when any pending flag is set, and otherwise hold IDLE.
REQ-021 SHALL, in GRANT with both flags pending, select the drink not served last (round-robin pointer), and otherwise select the single pending drink.
REQ-022 SHALL, in GRANT with credit >= selected price, deduct the price, clear that flag, update the pointer and go to DISPENSE.
REQ-023 SHALL, in GRANT with credit < selected price (credit consumed by an earlier grant), clear that flag, pulse o_deny and return to IDLE.
REQ-024 SHALL assert exactly one of o_coffee/o_sprite for DISPENSE_CYCLES cycles, then enter COOLDOWN for COOLDOWN_CYCLES cycles, then IDLE.
REQ-025 SHALL give o_coffee a latency of 2 edges from the request-sampling edge when idle (set pending, GRANT, DISPENSE).
REQ-026 SHALL apply a coin edge and a GRANT deduction in the same cycle as credit - price + 1, saturated at 3.
REQ-027 SHALL count coins and accept requests in every state, including during DISPENSE and COOLDOWN.
REQ-028 SHALL derive o_led_*, o_credit and o_busy combinationally from registered state only.
REQ-029 SHALL use an internal 3-bit phase counter for DISPENSE and COOLDOWN, reloaded on each state entry.

Reset
REQ-030 SHALL, while rst is high at a clk edge, force: state IDLE, credit 0, pending flags 0, round-robin pointer to coffee, counter 0, edge registers 0.
REQ-031 SHALL, from the edge after reset is applied, hold all outputs at 0, including mid-DISPENSE (that strobe drops and credit is lost).
REQ-032 SHALL treat an input held high across reset release as an edge on the first non-reset cycle.

Structure
REQ-033 SHALL take from shared package vend_pkg: the FSM state enum, the credit width/max constant, and the default price and timing constants.
REQ-034 SHALL instantiate sub-module vend_edge_detect (clk, rst, level in, 1-cycle pulse out) three times.

Verification
REQ-035 Bench SHALL check: 2 coins, then coffee -> credit 2->0, o_coffee high exactly 4 cycles 2 edges after the press, o_busy for 7 cycles.
REQ-036 Bench SHALL check: 1 coin, then coffee -> request ignored, no strobe, credit stays 1, o_led_coffee=0, o_led_sprite=1.
REQ-037 Bench SHALL check: 3 coins, then both buttons on the same cycle -> coffee dispensed first, sprite second, credit 0.
REQ-038 Bench SHALL check: 2 coins, sprite+coffee same cycle, pointer at sprite -> sprite dispensed, coffee GRANT sees credit 1 -> o_deny pulse.
REQ-039 Bench SHALL check: 4 coins -> credit 3, one o_coin_return pulse; a coin on the GRANT cycle of a sprite -> credit 3.
REQ-040 Bench SHALL check: rst asserted in the 2nd DISPENSE cycle -> next edge strobe 0, credit 0, state IDLE.
